// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core front end.
//   - fetch FSM state encoding
//   - funct3 encodings for conditional branches
//   - canonical NOP (addi x0, x0, 0)
package core_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator.
// Ports:
//   funct3_i  in  3   branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   a_i       in  32  first operand (rs1)
//   b_i       in  32  second operand (rs2)
//   taken_o   out 1   condition result; 0 for non-branch encodings 010/011
module branch_cmp
  import core_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = eq;
      BNE:     taken_o = ~eq;
      BLT:     taken_o = lt_s;
      BGE:     taken_o = ~lt_s;
      BLTU:    taken_o = lt_u;
      BGEU:    taken_o = ~lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch / branch unit of the multicycle RV32I core.
// Owns PC, old-PC and the instruction register, runs the instruction-memory
// read handshake, registers the branch condition for decode_unit and applies
// PC updates requested by decode_unit.
//
// Optional build macro: FETCH_TIMEOUT_EN -- enables a fetch watchdog that
// aborts a fetch after TIMEOUT_CYCLES cycles without imem_ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IRWrite_reg                 fetch request (accepted in IDLE only)
//   PCEn_reg, PCSrc_reg         PC write enable / source select
//   funct3_reg, rs1_data, rs2_data   branch compare inputs
//   alu_result, alu_out         PC+4 / branch-jump target
//   imem_req, imem_addr         read request, word-aligned address
//   imem_rdata, imem_ready      read data, completion strobe
//   instruction_reg, old_pc     fetched instruction and its PC
//   Cond_Chk_reg                registered branch condition
//   pc                          current PC
//   fetch_busy                  fetch outstanding
//   fetch_err                   sticky misalignment / timeout flag
module fetch_branch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite_reg,
  input  logic        PCEn_reg,
  input  logic        PCSrc_reg,
  input  logic [2:0]  funct3_reg,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instruction_reg,
  output logic        Cond_Chk_reg,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic        fetch_busy,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  old_pc_q, old_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         err_q, err_d;
  logic         cond_q;
  logic         cond_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  branch_cmp u_branch_cmp (
    .funct3_i (funct3_reg),
    .a_i      (rs1_data),
    .b_i      (rs2_data),
    .taken_o  (cond_d)
  );

  always_comb begin
    state_d  = state_q;
    old_pc_d = old_pc_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    req_d    = req_q;
    err_d    = err_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (IRWrite_reg) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          // The request always goes out word-aligned; misalignment is only flagged.
          addr_d  = {pc_q[31:2], 2'b00};
          if (pc_q[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          instr_d  = imem_rdata;
          old_pc_d = addr_q;
        end
`ifdef FETCH_TIMEOUT_EN
        // cnt_q counts completed FETCH cycles; abort on the TIMEOUT_CYCLES-th.
        else if (cnt_q == CNT_LAST) begin
          state_d  = ST_IDLE;
          req_d    = 1'b0;
          err_d    = 1'b1;
          instr_d  = NOP_INSTR;
          old_pc_d = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // PC update is independent of the FSM: the outstanding fetch uses addr_q.
    pc_d = pc_q;
    if (PCEn_reg) begin
      pc_d = PCSrc_reg ? alu_out : alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      addr_q   <= 32'h0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      cond_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      err_q    <= err_d;
      cond_q   <= cond_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign pc              = pc_q;
  assign old_pc          = old_pc_q;
  assign instruction_reg = instr_q;
  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  // busy is asserted exactly while a request is outstanding
  assign fetch_busy      = req_q;
  assign fetch_err       = err_q;
  assign Cond_Chk_reg    = cond_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed testbench for fetch_branch_unit: reset state, fetch handshake with
// wait states, concurrent PC+4, branch compares, taken branch, misaligned fetch,
// reset during fetch and (with FETCH_TIMEOUT_EN) the fetch watchdog.
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRWrite_reg;
  logic        PCEn_reg;
  logic        PCSrc_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instruction_reg;
  logic        Cond_Chk_reg;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        fetch_busy;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_branch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IRWrite_reg     (IRWrite_reg),
    .PCEn_reg        (PCEn_reg),
    .PCSrc_reg       (PCSrc_reg),
    .funct3_reg      (funct3_reg),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .alu_result      (alu_result),
    .alu_out         (alu_out),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .instruction_reg (instruction_reg),
    .Cond_Chk_reg    (Cond_Chk_reg),
    .pc              (pc),
    .old_pc          (old_pc),
    .fetch_busy      (fetch_busy),
    .fetch_err       (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // advance one rising edge, then settle so outputs are sampled off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch_case(input string tag, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic exp);
    funct3_reg = f3;
    rs1_data   = a;
    rs2_data   = b;
    tick();
    check(tag, {31'b0, Cond_Chk_reg}, {31'b0, exp});
  endtask

  initial begin
    reset       = 1'b1;
    IRWrite_reg = 1'b0;
    PCEn_reg    = 1'b0;
    PCSrc_reg   = 1'b0;
    funct3_reg  = 3'b010;
    rs1_data    = 32'h0;
    rs2_data    = 32'h0;
    alu_result  = 32'h0;
    alu_out     = 32'h0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;

    // ---- reset state
    tick();
    tick();
    check("rst_pc",       pc,              32'h0);
    check("rst_old_pc",   old_pc,          32'h0);
    check("rst_instr",    instruction_reg, 32'h0000_0013);
    check("rst_req",      {31'b0, imem_req},     32'h0);
    check("rst_addr",     imem_addr,       32'h0);
    check("rst_busy",     {31'b0, fetch_busy},   32'h0);
    check("rst_cond",     {31'b0, Cond_Chk_reg}, 32'h0);
    check("rst_err",      {31'b0, fetch_err},    32'h0);
    reset = 1'b0;

    // ---- fetch with 2 wait cycles, concurrent PC+4
    IRWrite_reg = 1'b1;
    PCEn_reg    = 1'b1;
    PCSrc_reg   = 1'b0;
    alu_result  = 32'h4;
    alu_out     = 32'h0000_0100;
    tick();
    IRWrite_reg = 1'b0;
    PCEn_reg    = 1'b0;
    check("f1_req0",  {31'b0, imem_req},   32'h1);
    check("f1_busy0", {31'b0, fetch_busy}, 32'h1);
    check("f1_addr0", imem_addr, 32'h0);
    check("f1_pc",    pc,        32'h4);
    tick();
    check("f1_addr1", imem_addr, 32'h0);
    check("f1_req1",  {31'b0, imem_req}, 32'h1);
    tick();
    check("f1_addr2", imem_addr, 32'h0);
    check("f1_req2",  {31'b0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    imem_rdata = 32'h015a_04b3;
    tick();
    imem_ready = 1'b0;
    check("f1_instr",  instruction_reg, 32'h015a_04b3);
    check("f1_old_pc", old_pc,          32'h0);
    check("f1_req_dn", {31'b0, imem_req},   32'h0);
    check("f1_busy_dn",{31'b0, fetch_busy}, 32'h0);
    check("f1_pc_hold",pc,              32'h4);

    // ---- branch compares (registered, 1 cycle)
    branch_case("beq_5_5",     3'b000, 32'd5,         32'd5, 1'b1);
    branch_case("bne_5_5",     3'b001, 32'd5,         32'd5, 1'b0);
    branch_case("blt_m1_1",    3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branch_case("bltu_m1_1",   3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branch_case("bge_m1_1",    3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branch_case("bgeu_m1_1",   3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branch_case("f3_010_zero", 3'b010, 32'd7,         32'd7, 1'b0);
    branch_case("f3_011_zero", 3'b011, 32'd3,         32'd9, 1'b0);

    // ---- taken branch and fetch from target
    PCEn_reg   = 1'b1;
    PCSrc_reg  = 1'b1;
    alu_out    = 32'h0000_0040;
    alu_result = 32'h0000_0008;
    tick();
    PCEn_reg = 1'b0;
    check("br_pc", pc, 32'h40);
    IRWrite_reg = 1'b1;
    tick();
    IRWrite_reg = 1'b0;
    check("br_addr", imem_addr, 32'h40);
    check("br_err",  {31'b0, fetch_err}, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0063;
    tick();
    imem_ready = 1'b0;
    check("br_instr",  instruction_reg, 32'h0000_0063);
    check("br_old_pc", old_pc,          32'h40);

    // ---- misaligned PC, ignored IRWrite in FETCH, reset mid-fetch
    PCEn_reg  = 1'b1;
    PCSrc_reg = 1'b1;
    alu_out   = 32'h0000_0042;
    tick();
    PCEn_reg = 1'b0;
    check("mis_pc", pc, 32'h42);
    IRWrite_reg = 1'b1;
    tick();
    check("mis_err",  {31'b0, fetch_err}, 32'h1);
    check("mis_addr", imem_addr, 32'h40);
    check("mis_req",  {31'b0, imem_req}, 32'h1);
    // IRWrite still high while in FETCH: must not disturb the request
    PCEn_reg  = 1'b1;
    PCSrc_reg = 1'b0;
    alu_result = 32'h0000_0080;
    tick();
    IRWrite_reg = 1'b0;
    PCEn_reg    = 1'b0;
    check("mis_addr_hold", imem_addr, 32'h40);
    check("mis_err_sticky",{31'b0, fetch_err}, 32'h1);
    check("mis_pc_upd",    pc, 32'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_err",   {31'b0, fetch_err}, 32'h0);
    check("mrst_req",   {31'b0, imem_req},  32'h0);
    check("mrst_busy",  {31'b0, fetch_busy}, 32'h0);
    check("mrst_pc",    pc, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    check("late_ready_instr", instruction_reg, 32'h0000_0013);
    check("late_ready_req",   {31'b0, imem_req}, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // ---- watchdog: ready held low, abort on the 16th FETCH cycle
    IRWrite_reg = 1'b1;
    tick();
    IRWrite_reg = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_req_before", {31'b0, imem_req}, 32'h1);
    tick();
    check("to_req",   {31'b0, imem_req},   32'h0);
    check("to_busy",  {31'b0, fetch_busy}, 32'h0);
    check("to_err",   {31'b0, fetch_err},  32'h1);
    check("to_instr", instruction_reg, 32'h0000_0013);
    check("to_old_pc", old_pc, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
